// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus for the sequential binary-to-BCD converter.
// The blank mask is present only when BIN2BCD_BLANK_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;
`endif

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
`ifdef BIN2BCD_BLANK_EN
    , input blank
`endif
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
`ifdef BIN2BCD_BLANK_EN
    , output blank
`endif
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank mask enabled by defining BIN2BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  bin_to_bcd_seq_if.slave bus
);
  localparam int WK_W  = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             stateReg;
  logic [BIN_W-1:0]   shiftReg;
  logic [WK_W-1:0]    workReg;
  logic               ovfFlag;
  logic [CNT_W-1:0]   bitCount;
  logic               busyReg;
  logic               doneReg;
  logic [WK_W-1:0]    bcdReg;
  logic               overflowReg;

  logic [WK_W-1:0]    adjWork;
  logic [WK_W-1:0]    nextWork;
  logic [BIN_W-1:0]   nextShift;
  logic               outBit;

  // Add-3 correction per digit, no carry between digits.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adjWork[4*gi +: 4] = (workReg[4*gi +: 4] >= 4'd5) ?
                                (workReg[4*gi +: 4] + 4'd3) : workReg[4*gi +: 4];
  end

  assign {outBit, nextWork, nextShift} = {adjWork, shiftReg, 1'b0};

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  logic [DIGITS-1:0] blankReg;
  logic [DIGITS-1:0] blankNext;

  // Units digit is never blanked so a zero result still shows one "0".
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_units
      assign blankNext[gi] = 1'b0;
    end else begin : g_upper
      assign blankNext[gi] = (nextWork[WK_W-1:4*gi] == '0);
    end
  end

  assign bus.blank = blankReg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      shiftReg    <= '0;
      workReg     <= '0;
      ovfFlag     <= 1'b0;
      bitCount    <= '0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      bcdReg      <= '0;
      overflowReg <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blankReg    <= BLANK_RST;
`endif
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE, DONE: begin
          if (bus.start) begin
            shiftReg <= bus.bin;
            workReg  <= '0;
            ovfFlag  <= 1'b0;
            bitCount <= '0;
            busyReg  <= 1'b1;
            stateReg <= SHIFT;
          end else begin
            busyReg  <= 1'b0;
            stateReg <= IDLE;
          end
        end
        SHIFT: begin
          shiftReg <= nextShift;
          workReg  <= nextWork;
          ovfFlag  <= ovfFlag | outBit;
          bitCount <= bitCount + 1'b1;
          if (bitCount == LAST_CNT) begin
            bcdReg      <= nextWork;
            overflowReg <= ovfFlag | outBit;
`ifdef BIN2BCD_BLANK_EN
            blankReg    <= blankNext;
`endif
            busyReg     <= 1'b0;
            doneReg     <= 1'b1;
            stateReg    <= DONE;
          end
        end
        default: begin
          busyReg  <= 1'b0;
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.bcd      = bcdReg;
  assign bus.overflow = overflowReg;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance checked against
// an arithmetic reference (mod / divide), with directed handshake cases.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;
  int   cycleCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) bus3 ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) bus2 ();

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else passCount++;
  endtask

  function automatic logic [31:0] refBcd(input int v, input int digits);
    int m;
    logic [31:0] r;
    m = v % (10 ** digits);
    r = '0;
    for (int d = 0; d < digits; d++) begin
      r = r | (32'(m % 10) << (4 * d));
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] refBlank(input int v, input int digits);
    int m;
    logic [31:0] r;
    m = v % (10 ** digits);
    r = '0;
    for (int i = 1; i < digits; i++)
      if (m / (10 ** i) == 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic getDone(input int sel);
    return (sel == 2) ? bus2.done : bus3.done;
  endfunction
  function automatic logic getBusy(input int sel);
    return (sel == 2) ? bus2.busy : bus3.busy;
  endfunction
  function automatic logic getOvf(input int sel);
    return (sel == 2) ? bus2.overflow : bus3.overflow;
  endfunction
  function automatic logic [31:0] getBcd(input int sel);
    return (sel == 2) ? 32'(bus2.bcd) : 32'(bus3.bcd);
  endfunction
`ifdef BIN2BCD_BLANK_EN
  function automatic logic [31:0] getBlank(input int sel);
    return (sel == 2) ? 32'(bus2.blank) : 32'(bus3.blank);
  endfunction
`endif

  task automatic setIn(input int sel, input logic st, input logic [7:0] val);
    if (sel == 2) begin bus2.start = st; bus2.bin = val; end
    else          begin bus3.start = st; bus3.bin = val; end
  endtask

  // Wait up to 20 falling edges for done; lat is 0 if it never came.
  task automatic waitDone(input int sel, output int lat);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (getDone(sel)) lat = k;
    end
  endtask

  // Called on a falling edge; one full conversion with timing and result checks.
  task automatic runConv(input int sel, input logic [7:0] val);
    int lat;
    int digits;
    bit busyOk;
    logic [31:0] expB;
    digits = (sel == 2) ? 2 : 3;
    expB = refBcd(int'(val), digits);
    setIn(sel, 1'b1, val);
    @(negedge clk);
    setIn(sel, 1'b0, 8'd0);
    checkVal("busy_after_accept", 32'(getBusy(sel)), 32'd1);
    busyOk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (getDone(sel)) lat = k;
      else if (!getBusy(sel)) busyOk = 1'b0;
    end
    checkVal("latency", 32'(lat), 32'd8);
    checkVal("busy_during_shift", 32'(busyOk), 32'd1);
    checkVal("busy_at_done", 32'(getBusy(sel)), 32'd0);
    checkVal("bcd", getBcd(sel), expB);
    checkVal("overflow", 32'(getOvf(sel)), 32'(int'(val) >= 10 ** digits));
`ifdef BIN2BCD_BLANK_EN
    checkVal("blank", getBlank(sel), refBlank(int'(val), digits));
`endif
    $display("conv digits=%0d bin=%0d bcd=%0h ovf=%0d lat=%0d", digits, val, getBcd(sel), getOvf(sel), lat);
    @(negedge clk);
    checkVal("done_one_cycle", 32'(getDone(sel)), 32'd0);
    checkVal("bcd_held", getBcd(sel), expB);
  endtask

  initial begin
    int lat;
    int lastCyc;
    logic [7:0] vals [4];
    setIn(3, 1'b0, 8'd0);
    setIn(2, 1'b0, 8'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkVal("rst_bcd", getBcd(3), 32'd0);
    checkVal("rst_done", 32'(getDone(3)), 32'd0);
    checkVal("rst_busy", 32'(getBusy(3)), 32'd0);
    checkVal("rst_ovf", 32'(getOvf(3)), 32'd0);
    checkVal("rst_bcd2", getBcd(2), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    checkVal("rst_blank", getBlank(3), 32'b110);
`endif

    runConv(3, 8'd255);
    runConv(3, 8'd0);
    runConv(3, 8'd7);
    runConv(2, 8'd200);
    runConv(2, 8'd99);
    for (int i = 0; i < 12; i++) runConv(3, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++) runConv(2, 8'($urandom_range(0, 255)));

    // start raised mid-conversion must not disturb the captured operand
    setIn(3, 1'b1, 8'd42);
    @(negedge clk);
    setIn(3, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    setIn(3, 1'b1, 8'd99);
    @(negedge clk);
    setIn(3, 1'b0, 8'd0);
    waitDone(3, lat);
    checkVal("ignored_start_seen", 32'(lat != 0), 32'd1);
    checkVal("ignored_start_bcd", getBcd(3), 32'h042);
    $display("conv ignored-start bcd=%0h", getBcd(3));
    @(negedge clk);

    // start held high: accepted values alternate 10/20, one result per 9 clocks
    vals = '{8'd10, 8'd20, 8'd10, 8'd20};
    setIn(3, 1'b1, vals[0]);
    @(negedge clk);
    bus3.bin = vals[1];
    lastCyc = -1;
    for (int r = 0; r < 4; r++) begin
      waitDone(3, lat);
      checkVal("b2b_done_seen", 32'(lat != 0), 32'd1);
      checkVal("b2b_bcd", getBcd(3), refBcd(int'(vals[r]), 3));
      if (lastCyc >= 0) checkVal("b2b_gap", 32'(cycleCnt - lastCyc), 32'd9);
      $display("conv back-to-back bin=%0d bcd=%0h cycle=%0d", vals[r], getBcd(3), cycleCnt);
      lastCyc = cycleCnt;
      if (r == 3) bus3.start = 1'b0;
      @(negedge clk);
      if (r + 2 < 4) bus3.bin = vals[r + 2];
    end
    waitDone(3, lat);
    checkVal("b2b_stopped", 32'(lat), 32'd0);

    // reset asserted during a conversion discards it
    setIn(3, 1'b1, 8'd123);
    @(negedge clk);
    setIn(3, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkVal("midrst_busy", 32'(getBusy(3)), 32'd0);
    checkVal("midrst_bcd", getBcd(3), 32'd0);
    rst_n = 1'b1;
    waitDone(3, lat);
    checkVal("midrst_no_done", 32'(lat), 32'd0);
    checkVal("midrst_bcd_after", getBcd(3), 32'd0);
    $display("conv mid-reset bcd=%0h", getBcd(3));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Iterative binary-to-BCD converter using the shift-and-add-3 (double dabble) method. It produces the packed BCD digit vectors that the BCD adder and display path consume, for example score and line counts held in binary. It processes one input bit per clock under a start/busy/done handshake and holds its result until the next conversion completes.

## Interface
- BIN_W, default 8: width of the binary input; also the number of shift cycles per conversion.
- DIGITS, default 3: number of BCD output digits.
- clk  input  1: rising-edge clock.
- rst_n  input  1: synchronous, active-low reset.
- start  input  1: request a conversion; sampled only when the block is ready (see Operation).
- bin  input  BIN_W: binary operand, captured on the accepting edge.
- busy  output  1: high while a conversion is in progress.
- done  output  1: one-cycle pulse marking that bcd and overflow are updated.
- bcd  output  4*DIGITS: packed result, digit 0 (units) in bits [3:0]; held between conversions.
- overflow  output  1: high when the input exceeded 10^DIGITS-1; updated together with bcd.
- blank  output  DIGITS: leading-zero blank mask; exists only when BIN2BCD_BLANK_EN is defined.

## Operation
- States:
  - IDLE: ready.
  - SHIFT: busy, bit counter 0..BIN_W-1.
  - DONE: one cycle; done=1, and the block is ready again.
- Accept:
  - In IDLE or DONE with start=1, capture bin into shift register sr.
  - Clear working register wk (4*DIGITS bits), the sticky overflow flag ovf, and the counter.
  - Go to SHIFT.
- No start in DONE: return to IDLE.
- start in SHIFT is ignored; the captured operand is unaffected.
- Each SHIFT cycle, in order:
  - Every 4-bit digit of wk that is >=5 gets +3 (4-bit add, no carry between digits).
  - Shift {wk, sr} left by one.
  - The bit leaving wk's MSB ORs into ovf.
  - Counter increments.
- When the counter reaches BIN_W-1, that shift's result is written to bcd and ovf|shifted-out bit is written to overflow. State goes to DONE.
- On overflow, bcd = bin mod 10^DIGITS. Lower digits stay valid.
- bcd and overflow change only on the edge entering DONE. They are stable at all other times.
- Reset, in any state including mid-conversion:
  - state=IDLE; busy=0, done=0, overflow=0, bcd=0.
  - blank = all ones except bit 0.
  - The in-flight conversion is discarded and produces no done.

## Timing
- Accepting edge E0: busy=1 is visible after E0.
- Shifts occur on edges E1..E_BIN_W.
- done=1, the new bcd and the new overflow are visible after E_BIN_W, for exactly one cycle of done. busy=0 in that same cycle.
- Latency: BIN_W clocks from accepting edge to done.
- Back-to-back: start held high gives one result every BIN_W+1 clocks. The DONE cycle doubles as the next accept cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- BIN2BCD_BLANK_EN defined:
  - The blank port exists, registered and updated with bcd.
  - blank[i]=1 when digit i and all higher digits are zero, for i>=1.
  - blank[0] is always 0, so zero displays as one "0".
  - Overflow does not force blanking.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset value: hold rst_n=0 for 2 clocks, then release.
  - Required: bcd=0, done=0, busy=0, overflow=0.
  - Required with the macro: blank=3'b110.
- Full-scale input, BIN_W=8, DIGITS=3: bin=255, start pulse at E0.
  - Required: busy high for E0..E7; done after E8.
  - Required: bcd=12'h255, overflow=0.
- Zero input: bin=0.
  - Required: bcd=12'h000, done after 8 clocks.
  - Required with the macro: blank=3'b110.
- Mid-range input: bin=7.
  - Required: bcd=12'h007.
  - Required with the macro: blank=3'b110.
- Overflow, DIGITS=2: bin=200.
  - Required: bcd=8'h00, overflow=1.
  - Then bin=99: bcd=8'h99, overflow=0.
- Handshake edge cases:
  - Start with bin=42, then assert start with bin=99 at E3: ignored; result is 12'h042.
  - Start held continuously alternating 10/20: results 12'h010 and 12'h020, done every 9 clocks.
  - rst_n=0 at E4 mid-conversion: no done pulse, bcd=0.
